// File: rtl/alu_result_fifo.sv
// Capture stage behind the combinational ALU: selects the result for the requested op,
// derives status flags and queues {select, result, flags} in a first-word-fall-through FIFO.
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int DROPW = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [2:0]                 select,
  input  logic [WIDTH-1:0]           and1,
  input  logic [WIDTH-1:0]           or1,
  input  logic [WIDTH-1:0]           sum,
  input  logic [WIDTH-1:0]           sub,
  input  logic [WIDTH-1:0]           xor1,
  input  logic                       carry,
  input  logic                       borrow,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_select,
  output logic [WIDTH-1:0]           out_result,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DROPW-1:0]           drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 + WIDTH + 4;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [EW-1:0]    head;
  logic             push;
  logic             pop;
  logic             drop;

  // Unused opcodes produce a zero result; the illegal flag tells the consumer why.
  always_comb begin
    result = '0;
    case (select)
      3'b000:  result = and1;
      3'b001:  result = or1;
      3'b010:  result = sum;
      3'b011:  result = sub;
      3'b100:  result = xor1;
      default: result = '0;
    endcase
    flags = {(result == '0),
             carry & (select == 3'b010),
             borrow & (select == 3'b011),
             (select > 3'b100)};
  end

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign drop      = in_valid & ~in_ready;

  assign head       = mem[rd_ptr];
  assign out_select = out_valid ? head[EW-1 -: 3]        : '0;
  assign out_result = out_valid ? head[WIDTH+3 -: WIDTH] : '0;
  assign out_flags  = out_valid ? head[3:0]              : '0;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {select, result, flags};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule
